// File: rtl/sd_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sd_read_sequencer
// Purpose  : Multi-block read sequencer in front of an SD card controller.
//            Issues one controller read per block and streams indexed bytes.
// Revision : 1.0 - initial release
// ============================================================================
module sd_read_sequencer #(
    parameter int BYTE_ADDR      = 0,
    parameter int BLOCK_BYTES    = 512,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] start_sector,
    input  logic [7:0]  num_blocks,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [8:0]  byte_index,
    output logic [7:0]  block_index,
    input  logic        sd_ready,
    input  logic        sd_byte_available,
    input  logic [7:0]  sd_dout,
    output logic        sd_rd,
    output logic [31:0] sd_address
);

    localparam logic [8:0]  C_LAST_BYTE    = 9'(BLOCK_BYTES - 1);
    localparam logic [21:0] C_TIMEOUT_LAST = 22'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_RECEIVE    = 3'd3,
        ST_NEXT       = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_avail_q, r_avail_qq;
    logic [21:0] r_timer, w_timer_nxt;
    logic [31:0] r_sector, w_sector_nxt;
    logic [7:0]  r_num_blocks, w_num_blocks_nxt;
    logic [7:0]  r_block_count, w_block_count_nxt;
    logic [8:0]  r_byte_count, w_byte_count_nxt;

    logic        w_busy_nxt, w_done_nxt, w_error_nxt, w_data_valid_nxt, w_sd_rd_nxt;
    logic [7:0]  w_data_out_nxt, w_block_index_nxt;
    logic [8:0]  w_byte_index_nxt;
    logic [31:0] w_sd_address_nxt, w_sector_addr;
    logic        w_byte_event, w_timed_out, w_timed_state, w_restart_timer, w_fail;

    // Strobe may stay high for several cycles; only its rising edge is a byte.
    assign w_byte_event  = r_avail_q & ~r_avail_qq;
    assign w_timed_out   = (r_timer == C_TIMEOUT_LAST);
    assign w_timed_state = (r_state == ST_WAIT_READY) || (r_state == ST_ISSUE) ||
                           (r_state == ST_RECEIVE);
    assign w_sector_addr = (BYTE_ADDR != 0) ? {r_sector[22:0], 9'd0} : r_sector;

    always_comb begin
        w_state_nxt       = r_state;
        w_sector_nxt      = r_sector;
        w_num_blocks_nxt  = r_num_blocks;
        w_block_count_nxt = r_block_count;
        w_byte_count_nxt  = r_byte_count;
        w_busy_nxt        = busy;
        w_done_nxt        = 1'b0;
        w_error_nxt       = error;
        w_data_out_nxt    = data_out;
        w_data_valid_nxt  = 1'b0;
        w_byte_index_nxt  = byte_index;
        w_block_index_nxt = block_index;
        w_sd_rd_nxt       = sd_rd;
        w_sd_address_nxt  = sd_address;
        w_restart_timer   = 1'b0;
        w_fail            = 1'b0;
        w_timer_nxt       = '0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_error_nxt = 1'b0;
                    if (num_blocks == 8'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_sector_nxt      = start_sector;
                        w_num_blocks_nxt  = num_blocks;
                        w_block_count_nxt = '0;
                        w_byte_count_nxt  = '0;
                        w_busy_nxt        = 1'b1;
                        w_state_nxt       = ST_WAIT_READY;
                    end
                end
            end
            ST_WAIT_READY: begin
                if (abort) begin
                    w_fail = 1'b1;
                end else if (sd_ready) begin
                    w_sd_address_nxt = w_sector_addr;
                    w_sd_rd_nxt      = 1'b1;
                    w_state_nxt      = ST_ISSUE;
                end else if (w_timed_out) begin
                    w_fail = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    w_fail = 1'b1;
                end else if (!sd_ready) begin
                    w_sd_rd_nxt = 1'b0;
                    w_state_nxt = ST_RECEIVE;
                end else if (w_timed_out) begin
                    w_fail = 1'b1;
                end
            end
            ST_RECEIVE: begin
                // Abort outranks a byte arriving in the same cycle.
                if (abort) begin
                    w_fail = 1'b1;
                end else if (w_byte_event) begin
                    w_data_out_nxt    = sd_dout;
                    w_data_valid_nxt  = 1'b1;
                    w_byte_index_nxt  = r_byte_count;
                    w_block_index_nxt = r_block_count;
                    w_restart_timer   = 1'b1;
                    if (r_byte_count == C_LAST_BYTE) begin
                        w_byte_count_nxt = '0;
                        w_state_nxt      = ST_NEXT;
                    end else begin
                        w_byte_count_nxt = r_byte_count + 9'd1;
                    end
                end else if (w_timed_out) begin
                    w_fail = 1'b1;
                end
            end
            ST_NEXT: begin
                if (abort) begin
                    w_fail = 1'b1;
                end else begin
                    w_block_count_nxt = r_block_count + 8'd1;
                    w_sector_nxt      = r_sector + 32'd1;
                    if (w_block_count_nxt == r_num_blocks) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_WAIT_READY;
                    end
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            ST_ERROR: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        if (w_fail) begin
            w_state_nxt = ST_ERROR;
            w_error_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_sd_rd_nxt = 1'b0;
        end

        if (w_timed_state && !w_restart_timer && (w_state_nxt == r_state)) begin
            w_timer_nxt = r_timer + 22'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_avail_q     <= 1'b0;
            r_avail_qq    <= 1'b0;
            r_timer       <= '0;
            r_sector      <= '0;
            r_num_blocks  <= '0;
            r_block_count <= '0;
            r_byte_count  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            byte_index    <= '0;
            block_index   <= '0;
            sd_rd         <= 1'b0;
            sd_address    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_avail_q     <= sd_byte_available;
            r_avail_qq    <= r_avail_q;
            r_timer       <= w_timer_nxt;
            r_sector      <= w_sector_nxt;
            r_num_blocks  <= w_num_blocks_nxt;
            r_block_count <= w_block_count_nxt;
            r_byte_count  <= w_byte_count_nxt;
            busy          <= w_busy_nxt;
            done          <= w_done_nxt;
            error         <= w_error_nxt;
            data_out      <= w_data_out_nxt;
            data_valid    <= w_data_valid_nxt;
            byte_index    <= w_byte_index_nxt;
            block_index   <= w_block_index_nxt;
            sd_rd         <= w_sd_rd_nxt;
            sd_address    <= w_sd_address_nxt;
        end
    end

endmodule
`default_nettype wire
